intersection_scheduler: RTL
===========================

INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- T_MIN, 8000: minimum green, ms.
- T_MAX, 30000: maximum green when another demand is pending, ms.
- T_AMB, 3000: amber duration, ms.
- T_RED, 1000: all-red clearance, ms.
- T_WALK, 10000: pedestrian walk duration, ms.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK, in, 1: system clock.
- reset, in, 1: reset, synchronous, active-high; clock CLK.
- en, in, 1: 0 freezes state and timer.
- ms_tick, in, 1: one-CLK pulse per millisecond.
- sens_th / sens_nn / sens_ns, in, 1 each: vehicle presence levels.
- ped_btn, in, 3: pedestrian buttons {N, TH2, TH1}.
- veh_go, out, 3: straight green {NS, NN, TH}.
- veh_amber, out, 3: amber {NS, NN, TH}.
- turn_go, out, 3: arrow green {NN_R, NN_L, TH_L}.
- ped_go, out, 3: walk {N, TH2, TH1}.
- phase, out, 3: current state encoding.
- phase_start, out, 1: one-cycle pulse on every state change.

Function
REQ-003 States and encodings SHALL be: ALL_RED=0, TH_G=1, TH_A=2, NN_G=3, NN_A=4, NS_G=5, NS_A=6, PED=7.
REQ-004 A 16-bit timer SHALL increment, saturating at 0xFFFF, on each CLK with ms_tick=1 and en=1, and SHALL clear to 0 on every state change.
REQ-005 Let e = timer+1 on a tick. All transitions SHALL occur only on a CLK edge with ms_tick=1 and en=1.
REQ-006 Fixed-duration states SHALL exit when e == duration: x_A after T_AMB to ALL_RED; PED after T_WALK to ALL_RED; ALL_RED after T_RED to the next phase.
REQ-007 Next-phase selection SHALL be round-robin in the order TH, NN, NS, PED, starting after the last served phase.
- Candidates: TH if sens_th; NN if sens_nn; NS if sens_ns; PED if ped_req.
- If no candidate exists, TH SHALL be selected.
REQ-008 A green state x_G SHALL exit to x_A when all of the following hold:
- e >= T_MIN;
- another candidate (REQ-007 set, excluding x) is present;
- own sensor is 0, or e >= T_MAX.
- Otherwise it SHALL hold green indefinitely (rest-in-green).
REQ-009 ped_req SHALL set when any ped_btn bit is 1 while phase != PED, and SHALL clear on entry to PED; presses during PED SHALL be ignored.
REQ-010 Output decode SHALL be:
- veh_go[i] = 1 only in the matching x_G.
- veh_amber[i] = 1 only in the matching x_A.
- turn_go[0] = 1 only in TH_G.
- turn_go[2:1] = 2'b11 only in NN_G.
- ped_go = 3'b111 only in PED.
- All outputs SHALL be registered/state-decoded so that they change in the same cycle as phase.
REQ-011 At most one of veh_go/turn_go groups or ped_go SHALL be nonzero in any cycle; no green SHALL follow an amber without an intervening ALL_RED.
REQ-012 With en=0, state, timer, and outputs SHALL hold, and ticks SHALL be ignored; ped_req latching SHALL still operate.
REQ-013 If ms_tick and a sensor change coincide, the sensor value sampled on that same edge SHALL be used.

Reset
REQ-014 reset=1 SHALL force, on the next CLK edge and regardless of en:
- phase=ALL_RED, timer=0, ped_req=0, last served=PED;
- veh_go=veh_amber=turn_go=ped_go=0, phase_start=0.
REQ-015 reset asserted mid-phase SHALL abort that phase immediately, with no amber, and restart from ALL_RED.

Verification (T_MIN=4, T_MAX=10, T_AMB=3, T_RED=2, T_WALK=6)
REQ-016 Reset, no inputs -> ALL_RED for 2 ticks, then TH_G; phase_start pulses once; veh_go=001; turn_go=001; holds TH_G indefinitely.
REQ-017 In TH_G with sens_th=0, assert sens_nn at tick 1 -> TH_A at tick 4, ALL_RED at tick 7, NN_G at tick 9, turn_go=110.
REQ-018 In TH_G with sens_th=1 and sens_ns=1 held -> TH_G lasts exactly 10 ticks, then TH_A, then ALL_RED, then NS_G.
REQ-019 Pulse ped_btn=100 for one CLK in NN_G with sens_nn=0 -> after amber and all-red, PED with ped_go=111 for 6 ticks; ped_req=0; a press during PED does not cause a second PED.
REQ-020 Assert reset during NS_G at tick 3, and separately hold en=0 for 20 ticks in TH_A -> the reset case returns to ALL_RED with all outputs 0 on the next edge; the en case keeps veh_amber=001 frozen with timer unchanged.

Source files
------------

// File: rtl/intersection_scheduler.sv
// Four-approach intersection phase sequencer: TH, NN and NS vehicle greens plus a pedestrian phase,
// with round-robin service, rest-in-green, ALL_RED clearance and a millisecond phase timer.
`timescale 1ns/1ps
module intersection_scheduler #(
   parameter int unsigned T_MIN  = 8000,
   parameter int unsigned T_MAX  = 30000,
   parameter int unsigned T_AMB  = 3000,
   parameter int unsigned T_RED  = 1000,
   parameter int unsigned T_WALK = 10000
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       en,
   input  logic       ms_tick,
   input  logic       sens_th,
   input  logic       sens_nn,
   input  logic       sens_ns,
   input  logic [2:0] ped_btn,
   output logic [2:0] veh_go,
   output logic [2:0] veh_amber,
   output logic [2:0] turn_go,
   output logic [2:0] ped_go,
   output logic [2:0] phase,
   output logic       phase_start
);

   typedef enum logic [2:0] {
      ALL_RED = 3'd0,
      TH_G    = 3'd1,
      TH_A    = 3'd2,
      NN_G    = 3'd3,
      NN_A    = 3'd4,
      NS_G    = 3'd5,
      NS_A    = 3'd6,
      PED     = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      SRV_TH  = 2'd0,
      SRV_NN  = 2'd1,
      SRV_NS  = 2'd2,
      SRV_PED = 2'd3
   } srv_t;

   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic        ped_req_q, ped_req_d;
   srv_t        last_q, last_d;

   logic [2:0]  veh_go_q, veh_amber_q, turn_go_q, ped_go_q;
   logic [2:0]  veh_go_d, veh_amber_d, turn_go_d, ped_go_d;
   logic        phase_start_q, phase_start_d;

   logic        tick;
   logic [31:0] e;
   logic [3:0]  cand;
   logic [1:0]  idx;
   logic [1:0]  own;
   logic        found;
   logic        other;
   logic        green_exit;
   srv_t        pick;

   always_comb begin
      tick  = ms_tick & en;
      e     = 32'(timer_q) + 32'd1;
      cand  = {ped_req_q, sens_ns, sens_nn, sens_th};

      // Round-robin search starts one past the last served phase; TH when nothing is waiting.
      pick  = SRV_TH;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 1; k <= 4; k++) begin
         idx = last_q + 2'(k);
         if (!found && cand[idx]) begin
            pick  = srv_t'(idx);
            found = 1'b1;
         end
      end

      case (state_q)
         NN_G:    own = 2'd1;
         NS_G:    own = 2'd2;
         default: own = 2'd0;
      endcase
      other      = |(cand & ~(4'b0001 << own));
      green_exit = (e >= T_MIN) && other && (!cand[own] || (e >= T_MAX));

      state_d = state_q;
      last_d  = last_q;
      if (tick) begin
         case (state_q)
            ALL_RED: begin
               if (e == T_RED) begin
                  last_d = pick;
                  case (pick)
                     SRV_TH:  state_d = TH_G;
                     SRV_NN:  state_d = NN_G;
                     SRV_NS:  state_d = NS_G;
                     default: state_d = PED;
                  endcase
               end
            end
            TH_G, NN_G, NS_G: begin
               if (green_exit) state_d = state_t'(state_q + 3'd1);
            end
            TH_A, NN_A, NS_A: begin
               if (e == T_AMB) state_d = ALL_RED;
            end
            default: begin
               if (e == T_WALK) state_d = ALL_RED;
            end
         endcase
      end

      // Request latching runs even while frozen; entering PED wins over a same-edge press.
      ped_req_d = ped_req_q | ((|ped_btn) && (state_q != PED));
      if (state_d == PED && state_q != PED) ped_req_d = 1'b0;

      timer_d = timer_q;
      if (state_d != state_q)              timer_d = '0;
      else if (tick && (timer_q != '1))    timer_d = timer_q + 16'd1;

      veh_go_d      = {state_d == NS_G, state_d == NN_G, state_d == TH_G};
      veh_amber_d   = {state_d == NS_A, state_d == NN_A, state_d == TH_A};
      turn_go_d     = {state_d == NN_G, state_d == NN_G, state_d == TH_G};
      ped_go_d      = {3{state_d == PED}};
      phase_start_d = (state_d != state_q);
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q       <= ALL_RED;
         timer_q       <= '0;
         ped_req_q     <= 1'b0;
         last_q        <= SRV_PED;
         veh_go_q      <= '0;
         veh_amber_q   <= '0;
         turn_go_q     <= '0;
         ped_go_q      <= '0;
         phase_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         ped_req_q     <= ped_req_d;
         last_q        <= last_d;
         veh_go_q      <= veh_go_d;
         veh_amber_q   <= veh_amber_d;
         turn_go_q     <= turn_go_d;
         ped_go_q      <= ped_go_d;
         phase_start_q <= phase_start_d;
      end
   end

   assign veh_go      = veh_go_q;
   assign veh_amber   = veh_amber_q;
   assign turn_go     = turn_go_q;
   assign ped_go      = ped_go_q;
   assign phase       = state_q;
   assign phase_start = phase_start_q;

endmodule
